// File: rtl/fx_mac_seq.sv
// fx_mac_seq: streams K weight/activation pairs from local banks into one fixed-point MAC slice,
// captures its result and enforces the post-result idle gap. Define FX_MAC_SEQ_TIMEOUT_EN for the WAIT watchdog.
module fx_mac_seq #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned K       = 9,
  parameter int unsigned WK      = $clog2(K),
  parameter int unsigned GAP     = 6,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cfg_we,
  input  logic             cfg_sel,
  input  logic [WK-1:0]    cfg_addr,
  input  logic [WIDTH-1:0] cfg_wdata,
  input  logic             start,
  output logic             busy,
  output logic             mac_vld,
  output logic [WIDTH-1:0] mac_win,
  output logic [WIDTH-1:0] mac_din,
  input  logic [WIDTH-1:0] mac_acc,
  input  logic             mac_vld_o,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             err_timeout
);

  // One counter serves both the GAP countdown and the WAIT watchdog.
  localparam int unsigned CntMax = (TIMEOUT > GAP) ? TIMEOUT : GAP;
  localparam int unsigned CW     = $clog2(CntMax + 1);

  typedef enum logic [2:0] {StIdle, StStream, StWait, StHold, StGap} state_e;

  state_e           state_q, state_d;
  logic [WK-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] w_bank_q [K];
  logic [WIDTH-1:0] a_bank_q [K];

  logic             busy_q, mac_vld_q, res_valid_q;
  logic [WIDTH-1:0] mac_win_q, mac_din_q, res_data_q;
  logic             mac_vld_d;
  logic [WIDTH-1:0] win_d, din_d, res_data_d;
  logic             cfg_ok, timeout_hit;

  assign cfg_ok = cfg_we && (state_q == StIdle) && ({1'b0, cfg_addr} < (WK + 1)'(K));

`ifdef FX_MAC_SEQ_TIMEOUT_EN
  logic err_q, err_d;

  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));
  assign err_d       = err_q | ((state_q == StWait) && !mac_vld_o && timeout_hit);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    res_data_d = res_data_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StStream;
          idx_d   = '0;
        end
      end
      StStream: begin
        if (idx_q == WK'(K - 1)) begin
          state_d = StWait;
          cnt_d   = '0;
        end else begin
          idx_d = idx_q + WK'(1);
        end
      end
      StWait: begin
        if (mac_vld_o) begin
          res_data_d = mac_acc;
          state_d    = StHold;
        end else if (timeout_hit) begin
          state_d = StGap;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StHold: begin
        if (res_ready) begin
          state_d = StGap;
          cnt_d   = '0;
        end
      end
      StGap: begin
        if (cnt_q == CW'(GAP - 1)) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    mac_vld_d = (state_d == StStream);
    win_d     = mac_vld_d ? w_bank_q[idx_d] : '0;
    din_d     = mac_vld_d ? a_bank_q[idx_d] : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      mac_vld_q   <= 1'b0;
      mac_win_q   <= '0;
      mac_din_q   <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      busy_q      <= (state_d != StIdle);
      mac_vld_q   <= mac_vld_d;
      mac_win_q   <= win_d;
      mac_din_q   <= din_d;
      res_valid_q <= (state_d == StHold);
      res_data_q  <= res_data_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < K; i++) begin
        w_bank_q[i] <= '0;
        a_bank_q[i] <= '0;
      end
    end else if (cfg_ok) begin
      if (cfg_sel) begin
        a_bank_q[cfg_addr] <= cfg_wdata;
      end else begin
        w_bank_q[cfg_addr] <= cfg_wdata;
      end
    end
  end

  assign busy      = busy_q;
  assign mac_vld   = mac_vld_q;
  assign mac_win   = mac_win_q;
  assign mac_din   = mac_din_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

endmodule

// File: tb/tb_fx_mac_seq.sv
// Bench for fx_mac_seq: stub MAC, bank model, operand/result scoreboard and window timing checks.
module tb_fx_mac_seq;

  localparam int WIDTH   = 8;
  localparam int K       = 9;
  localparam int WK      = 4;
  localparam int GAP     = 6;
  localparam int TIMEOUT = 32;

  logic             clk;
  logic             rstn;
  logic             cfg_we, cfg_sel;
  logic [WK-1:0]    cfg_addr;
  logic [WIDTH-1:0] cfg_wdata;
  logic             start, busy, mac_vld;
  logic [WIDTH-1:0] mac_win, mac_din, mac_acc;
  logic             mac_vld_o, res_valid, res_ready;
  logic [WIDTH-1:0] res_data;
  logic             err_timeout;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0]   w_ref [K];
  logic [WIDTH-1:0]   a_ref [K];
  logic [2*WIDTH-1:0] op_q [$];
  logic [WIDTH-1:0]   res_q [$];

  bit stub_en;
  bit stub_fix;
  int stub_dly;

  fx_mac_seq #(
    .WIDTH  (WIDTH),
    .K      (K),
    .GAP    (GAP),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .cfg_we     (cfg_we),
    .cfg_sel    (cfg_sel),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .start      (start),
    .busy       (busy),
    .mac_vld    (mac_vld),
    .mac_win    (mac_win),
    .mac_din    (mac_din),
    .mac_acc    (mac_acc),
    .mac_vld_o  (mac_vld_o),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Stub MAC: after the K-th operand, strobe a result stub_dly cycles later; garbage otherwise.
  initial begin : stub_mac
    int n;
    logic [WIDTH-1:0] v;
    n         = 0;
    mac_vld_o = 1'b0;
    mac_acc   = '0;
    forever begin
      @(negedge clk);
      mac_vld_o = 1'b0;
      mac_acc   = WIDTH'($urandom);
      if (!rstn) begin
        n = 0;
      end else if (mac_vld) begin
        n++;
        if (n == K) begin
          n = 0;
          if (stub_en) begin
            repeat (stub_dly) begin
              @(negedge clk);
              mac_acc = WIDTH'($urandom);
            end
            v         = stub_fix ? 8'h5A : WIDTH'($urandom);
            mac_vld_o = 1'b1;
            mac_acc   = v;
            res_q.push_back(v);
          end
        end
      end
    end
  end

  // Scoreboard monitor: operands on every mac_vld cycle, result on every handshake.
  initial begin : monitor
    logic             rv_prev, hs_prev;
    logic [WIDTH-1:0] rd_prev;
    logic [2*WIDTH-1:0] e;
    rv_prev = 1'b0;
    hs_prev = 1'b0;
    rd_prev = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        rv_prev = 1'b0;
        hs_prev = 1'b0;
      end else begin
        if (mac_vld) begin
          if (op_q.size() == 0) begin
            chk("unexpected_mac_vld", 1, 0);
          end else begin
            e = op_q.pop_front();
            chk("mac_win", int'(mac_win), int'(e[2*WIDTH-1:WIDTH]));
            chk("mac_din", int'(mac_din), int'(e[WIDTH-1:0]));
          end
        end
        if (res_valid) begin
          chk("mac_vld_in_hold", int'(mac_vld), 0);
          if (rv_prev && !hs_prev) chk("res_data_stable", int'(res_data), int'(rd_prev));
          if (res_ready) begin
            if (res_q.size() == 0) chk("unexpected_result", 1, 0);
            else chk("res_data", int'(res_data), int'(res_q.pop_front()));
          end
        end
        rv_prev = res_valid;
        hs_prev = res_valid && res_ready;
        rd_prev = res_data;
      end
    end
  end

  task automatic cfg_write(input logic sel, input int addr, input int data);
    cfg_we    = 1'b1;
    cfg_sel   = sel;
    cfg_addr  = WK'(addr);
    cfg_wdata = WIDTH'(data);
    @(posedge clk);
    #1 cfg_we = 1'b0;
  endtask

  // One window from start; entered and left at posedge+1 with the DUT idle.
  task automatic run_window(input int hold, input int d, input bit wr_stream, input bit start_hold,
                            input int rst_at, input bit timeout_case);
    int first_vld, nvld, first_rv, nrv, idle_c, first_err, exp_nrv;
    for (int i = 0; i < K; i++) op_q.push_back({w_ref[i], a_ref[i]});
    stub_dly  = d;
    res_ready = (hold == 0);
    first_vld = -1; nvld = 0; first_rv = -1; nrv = 0; idle_c = -1; first_err = -1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 120; c++) begin
      @(negedge clk);
      if (c == 1) chk("busy_rise", int'(busy), 1);
      if (mac_vld) begin
        if (first_vld < 0) first_vld = c;
        nvld++;
      end
      if (res_valid) begin
        if (first_rv < 0) first_rv = c;
        nrv++;
      end
      if (err_timeout && first_err < 0) first_err = c;
      if (!busy) begin
        idle_c = c;
        break;
      end
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
      start  = 1'b0;
      if (wr_stream && c == 1) begin
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = '0; cfg_wdata = 8'h7F;
      end
      if (res_valid && nrv >= hold) res_ready = 1'b1;
      if (start_hold && res_valid && nrv == 3) start = 1'b1;
      if (rst_at > 0 && c == rst_at - 1) begin
        rstn = 1'b0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_mac_vld", int'(mac_vld), 0);
        chk("rst_mac_win", int'(mac_win), 0);
        chk("rst_mac_din", int'(mac_din), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_res_data", int'(res_data), 0);
        chk("rst_err", int'(err_timeout), 0);
        return;
      end
    end
    chk("first_vld_cycle", first_vld, 1);
    chk("vld_cycles", nvld, K);
    if (!timeout_case) begin
      exp_nrv = (hold == 0) ? 1 : hold + 1;
      chk("first_res_valid_cycle", first_rv, K + d + 1);
      chk("res_valid_cycles", nrv, exp_nrv);
      chk("idle_cycle", idle_c, K + d + 1 + exp_nrv + GAP);
    end else begin
      chk("to_no_res_valid", nrv, 0);
`ifdef FX_MAC_SEQ_TIMEOUT_EN
      chk("to_err_cycle", first_err, K + 1 + TIMEOUT);
      chk("to_idle_cycle", idle_c, K + 1 + TIMEOUT + GAP);
      chk("to_err_sticky", int'(err_timeout), 1);
`else
      chk("to_busy_held", int'(busy), 1);
      chk("to_err_low", int'(err_timeout), 0);
`endif
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    int wv;
    rstn = 1'b0; start = 1'b0; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    res_ready = 1'b0; stub_en = 1'b1; stub_fix = 1'b1; stub_dly = 4;
    for (int i = 0; i < K; i++) begin
      w_ref[i] = '0;
      a_ref[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_mac_vld", int'(mac_vld), 0);
    chk("reset_mac_win", int'(mac_win), 0);
    chk("reset_res_valid", int'(res_valid), 0);
    chk("reset_res_data", int'(res_data), 0);
    chk("reset_err", int'(err_timeout), 0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Weights 1..9, data 9..1, stub result 0x5A four cycles after the last operand.
    for (int i = 0; i < K; i++) begin
      cfg_write(1'b0, i, i + 1);
      w_ref[i] = WIDTH'(i + 1);
      cfg_write(1'b1, i, K - i);
      a_ref[i] = WIDTH'(K - i);
    end
    run_window(0, 4, 1'b0, 1'b0, 0, 1'b0);

    // Consumer stalls 10 cycles; a start during HOLD must be ignored.
    run_window(10, 4, 1'b0, 1'b1, 0, 1'b0);
    @(negedge clk);
    chk("second_start_ignored", int'(busy), 0);
    @(posedge clk);
    #1;

    // Weight write during STREAM is dropped; the next window still uses the old weight[0].
    run_window(0, 4, 1'b1, 1'b0, 0, 1'b0);
    run_window(0, 4, 1'b0, 1'b0, 0, 1'b0);

    // Out-of-range address is dropped.
    cfg_write(1'b0, 12, 8'h33);

    stub_fix = 1'b0;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < K; i++) begin
        wv = int'($urandom_range(0, 255));
        cfg_write(1'b0, i, wv);
        w_ref[i] = WIDTH'(wv);
        wv = int'($urandom_range(0, 255));
        cfg_write(1'b1, i, wv);
        a_ref[i] = WIDTH'(wv);
      end
      if (it % 2 == 1) cfg_write(1'(it % 4 == 1), K + int'($urandom_range(0, 6)), 8'hC3);
      run_window(int'($urandom_range(0, 3)), int'($urandom_range(1, 6)), 1'b0, 1'b0, 0, 1'b0);
    end

    // Reset at index 4 of STREAM aborts the window and clears the banks.
    run_window(0, 4, 1'b0, 1'b0, 5, 1'b0);
    op_q.delete();
    for (int i = 0; i < K; i++) begin
      w_ref[i] = '0;
      a_ref[i] = '0;
    end
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("busy_after_reset", int'(busy), 0);
    @(posedge clk);
    #1;
    run_window(0, 4, 1'b0, 1'b0, 0, 1'b0);

    // MAC never answers.
    stub_en = 1'b0;
    run_window(0, 4, 1'b0, 1'b0, 0, 1'b1);
    rstn = 1'b0;
    #1;
    chk("err_cleared_by_reset", int'(err_timeout), 0);
    chk("busy_cleared_by_reset", int'(busy), 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    repeat (2) @(posedge clk);

    chk("op_queue_drained", op_q.size(), 0);
    chk("res_queue_drained", res_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
